// File: rtl/wnn_seq_arbiter.sv
// wnn_seq_arbiter: two-port CHECK/WRITE arbiter for the WNN sequence-number
// repository. Port 0 is KIP rx and port 1 is KIP tx.
// Ports:
//   req_*      per-port request beats (tuser = keep the lock)
//   rsp_*      CHECK responses, routed to the issuing port
//   to_WNN_*   serialized requests; from_WNN_* responses
//   o_grant    one-hot owner; o_lock_timeout and o_stray_rsp are pulses
// Option: define WNN_ARB_LOCK_TIMEOUT_EN to break an abandoned lock.
module wnn_seq_arbiter #(
  parameter int unsigned RPN_MSG_TYPE_WIDTH        = 8,
  parameter int unsigned AXIS_WAN_TDEST_WIDTH      = 8,
  parameter int unsigned WAN_SEQUENCE_NUMBER_WIDTH = 32,
  parameter int unsigned MSG_CHECK                 = 1,
  parameter int unsigned MSG_NOP                   = 0,
  parameter int unsigned LOCK_TIMEOUT_CYCLES       = 256
) (
  input  logic                                  i_clk,
  input  logic                                  i_ap_rst_n,
  input  logic [1:0]                            req_tvalid,
  output logic [1:0]                            req_tready,
  input  logic [2*RPN_MSG_TYPE_WIDTH-1:0]       req_tdata,
  input  logic [2*AXIS_WAN_TDEST_WIDTH-1:0]     req_tdest,
  input  logic [1:0]                            req_tuser,
  output logic [1:0]                            rsp_tvalid,
  input  logic [1:0]                            rsp_tready,
  output logic [WAN_SEQUENCE_NUMBER_WIDTH-1:0]  rsp_tdata,
  output logic [AXIS_WAN_TDEST_WIDTH-1:0]       rsp_tdest,
  output logic                                  rsp_tuser,
  output logic                                  to_WNN_tvalid,
  input  logic                                  to_WNN_tready,
  output logic [RPN_MSG_TYPE_WIDTH-1:0]         to_WNN_tdata,
  output logic [AXIS_WAN_TDEST_WIDTH-1:0]       to_WNN_tdest,
  input  logic                                  from_WNN_tvalid,
  output logic                                  from_WNN_tready,
  input  logic [WAN_SEQUENCE_NUMBER_WIDTH-1:0]  from_WNN_tdata,
  input  logic [AXIS_WAN_TDEST_WIDTH-1:0]       from_WNN_tdest,
  input  logic                                  from_WNN_tuser,
  output logic [1:0]                            o_grant,
  output logic                                  o_lock_timeout,
  output logic                                  o_stray_rsp
);

  localparam int unsigned MW = RPN_MSG_TYPE_WIDTH;
  localparam int unsigned DW = AXIS_WAN_TDEST_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FWD,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t          st_q, st_d;
  logic            g_q, g_d;
  logic            last_q, last_d;
  logic            lock_q, lock_d;
  logic [DW-1:0]   tdest_q, tdest_d;

`ifdef WNN_ARB_LOCK_TIMEOUT_EN
  localparam int unsigned CW = $clog2(LOCK_TIMEOUT_CYCLES);
  logic [CW-1:0]   cnt_q, cnt_d;
`else
  localparam int unsigned UNUSED_TO = LOCK_TIMEOUT_CYCLES;
`endif

  // r_tdest is kept for debug visibility only; mismatches are delivered.
  logic unused_tdest;
  assign unused_tdest = ^tdest_q;

  logic [MW-1:0] s_tdata;
  logic [DW-1:0] s_tdest;
  logic          s_valid;
  logic          s_user;
  logic          s_nop;
  logic          s_check;
  logic          s_rdy;

  assign s_tdata = g_q ? req_tdata[2*MW-1:MW] : req_tdata[MW-1:0];
  assign s_tdest = g_q ? req_tdest[2*DW-1:DW] : req_tdest[DW-1:0];
  assign s_valid = req_tvalid[g_q];
  assign s_user  = req_tuser[g_q];
  assign s_nop   = (s_tdata == MW'(MSG_NOP));
  assign s_check = (s_tdata == MW'(MSG_CHECK));
  assign s_rdy   = s_nop | to_WNN_tready;

  assign to_WNN_tdata = s_tdata;
  assign to_WNN_tdest = s_tdest;
  assign rsp_tdata    = from_WNN_tdata;
  assign rsp_tdest    = from_WNN_tdest;
  assign rsp_tuser    = from_WNN_tuser;
  assign o_grant      = (st_q == S_IDLE) ? 2'b00
                      : (g_q ? 2'b10 : 2'b01);
  assign o_stray_rsp  = from_WNN_tvalid & (st_q != S_WAIT);

  always_comb begin
    st_d            = st_q;
    g_d             = g_q;
    last_d          = last_q;
    lock_d          = lock_q;
    tdest_d         = tdest_q;
    req_tready      = '0;
    rsp_tvalid      = '0;
    to_WNN_tvalid   = 1'b0;
    from_WNN_tready = 1'b1;
    o_lock_timeout  = 1'b0;
`ifdef WNN_ARB_LOCK_TIMEOUT_EN
    cnt_d           = '0;
`endif
    unique case (st_q)
      S_IDLE: begin
        if (|req_tvalid) begin
          // On a tie the port not granted last wins.
          g_d    = (&req_tvalid) ? ~last_q : req_tvalid[1];
          last_d = g_d;
          st_d   = S_FWD;
        end
      end
      S_FWD: begin
        to_WNN_tvalid   = s_valid & ~s_nop;
        req_tready[g_q] = s_rdy;
        if (s_valid && s_rdy) begin
          if (s_check) begin
            st_d    = S_WAIT;
            lock_d  = s_user;
            tdest_d = s_tdest;
          end else if (s_user) begin
            st_d = S_HOLD;
          end else begin
            st_d = S_IDLE;
          end
        end
      end
      S_WAIT: begin
        rsp_tvalid[g_q] = from_WNN_tvalid;
        from_WNN_tready = rsp_tready[g_q];
        if (from_WNN_tvalid && rsp_tready[g_q]) begin
          st_d = lock_q ? S_HOLD : S_IDLE;
        end
      end
      S_HOLD: begin
        if (s_valid) begin
          st_d = S_FWD;
        end
`ifdef WNN_ARB_LOCK_TIMEOUT_EN
        else if (cnt_q == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
          o_lock_timeout = 1'b1;
          lock_d         = 1'b0;
          st_d           = S_IDLE;
        end else begin
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end
`endif
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      st_q    <= S_IDLE;
      g_q     <= 1'b0;
      last_q  <= 1'b1;
      lock_q  <= 1'b0;
      tdest_q <= '0;
`ifdef WNN_ARB_LOCK_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      st_q    <= st_d;
      g_q     <= g_d;
      last_q  <= last_d;
      lock_q  <= lock_d;
      tdest_q <= tdest_d;
`ifdef WNN_ARB_LOCK_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_wnn_seq_arbiter.sv
// tb_wnn_seq_arbiter: scoreboard bench for wnn_seq_arbiter.
// Expected WNN beats and responses are queued; monitors pop and compare.
module tb_wnn_seq_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_tvalid, req_tready, req_tuser;
  logic [15:0] req_tdata, req_tdest;
  logic [1:0]  rsp_tvalid;
  logic [1:0]  rsp_tready = 2'b11;
  logic [31:0] rsp_tdata;
  logic [7:0]  rsp_tdest;
  logic        rsp_tuser;
  logic        to_WNN_tvalid;
  logic        to_WNN_tready = 1'b1;
  logic [7:0]  to_WNN_tdata, to_WNN_tdest;
  logic        from_WNN_tvalid = 1'b0;
  logic        from_WNN_tready;
  logic [31:0] from_WNN_tdata = '0;
  logic [7:0]  from_WNN_tdest = '0;
  logic        from_WNN_tuser = 1'b0;
  logic [1:0]  o_grant;
  logic        o_lock_timeout, o_stray_rsp;

  logic       tv0 = 0, tv1 = 0, tu0 = 0, tu1 = 0;
  logic [7:0] td0 = 0, td1 = 0, ts0 = 0, ts1 = 0;
  assign req_tvalid = {tv1, tv0};
  assign req_tuser  = {tu1, tu0};
  assign req_tdata  = {td1, td0};
  assign req_tdest  = {ts1, ts0};

  wnn_seq_arbiter #(.LOCK_TIMEOUT_CYCLES(8)) dut (
    .i_clk(clk), .i_ap_rst_n(rst_n),
    .req_tvalid(req_tvalid), .req_tready(req_tready),
    .req_tdata(req_tdata), .req_tdest(req_tdest), .req_tuser(req_tuser),
    .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready),
    .rsp_tdata(rsp_tdata), .rsp_tdest(rsp_tdest), .rsp_tuser(rsp_tuser),
    .to_WNN_tvalid(to_WNN_tvalid), .to_WNN_tready(to_WNN_tready),
    .to_WNN_tdata(to_WNN_tdata), .to_WNN_tdest(to_WNN_tdest),
    .from_WNN_tvalid(from_WNN_tvalid), .from_WNN_tready(from_WNN_tready),
    .from_WNN_tdata(from_WNN_tdata), .from_WNN_tdest(from_WNN_tdest),
    .from_WNN_tuser(from_WNN_tuser),
    .o_grant(o_grant), .o_lock_timeout(o_lock_timeout),
    .o_stray_rsp(o_stray_rsp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int to_cnt = 0, to_cyc = 0, rsp0_cyc = 0, stray_cnt = 0;
  bit rsp_en = 1;
  int rsp_n = 0;
  logic [16:0] exp_wnn[$];
  logic [32:0] exp_rsp[$];
  logic [7:0]  pend_q[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // WNN request monitor
  initial forever begin
    @(negedge clk);
    if (to_WNN_tvalid && to_WNN_tready) begin
      if (exp_wnn.size() == 0) begin
        chk("wnn_unexpected", {o_grant[1], to_WNN_tdata, to_WNN_tdest}, '1);
      end else begin
        chk("wnn_beat", {o_grant[1], to_WNN_tdata, to_WNN_tdest},
            exp_wnn.pop_front());
      end
    end
  end

  // response / pulse monitor
  initial forever begin
    @(negedge clk);
    chk("rsp_onehot", rsp_tvalid == 2'b11, 0);
    for (int p = 0; p < 2; p++) begin
      if (rsp_tvalid[p] && rsp_tready[p]) begin
        if (p == 0) rsp0_cyc = cyc;
        if (exp_rsp.size() == 0) begin
          chk("rsp_unexpected", {p[0], rsp_tdata}, '1);
        end else begin
          chk("rsp_beat", {p[0], rsp_tdata}, exp_rsp.pop_front());
        end
      end
    end
    if (o_lock_timeout) begin
      to_cnt++;
      to_cyc = cyc;
    end
    if (o_stray_rsp) stray_cnt++;
  end

  // WNN model: answers each forwarded CHECK one cycle later
  initial forever begin
    bit hs;
    @(negedge clk);
    hs = 0;
    if (rsp_en) begin
      if (to_WNN_tvalid && to_WNN_tready && to_WNN_tdata == 8'd1)
        pend_q.push_back(to_WNN_tdest);
      hs = from_WNN_tvalid && from_WNN_tready;
    end
    @(posedge clk);
    #1;
    if (rsp_en) begin
      if (hs) begin
        from_WNN_tvalid = 0;
      end else if (!from_WNN_tvalid && pend_q.size() > 0) begin
        from_WNN_tdest  = pend_q.pop_front();
        from_WNN_tdata  = 32'h10 + rsp_n;
        from_WNN_tvalid = 1;
        rsp_n++;
      end
    end
  end

  task automatic drive(input bit p, input bit v, input logic [7:0] t,
                       input logic [7:0] d, input bit l);
    if (p) begin
      tv1 = v; td1 = t; ts1 = d; tu1 = l;
    end else begin
      tv0 = v; td0 = t; ts0 = d; tu0 = l;
    end
  endtask

  // called and returns at posedge+1
  task automatic send(input bit p, input logic [7:0] t,
                      input logic [7:0] d, input bit l);
    bit ok = 0;
    int n = 0;
    drive(p, 1, t, d, l);
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = req_tready[p];
      n++;
      @(posedge clk);
      #1;
    end
    drive(p, 0, t, d, 0);
    chk("send_accepted", ok, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_wnn.size() != 0 || exp_rsp.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain", exp_wnn.size() + exp_rsp.size(), 0);
  endtask

  initial begin
    #3;
    chk("rst_grant", o_grant, 2'b00);
    chk("rst_req_tready", req_tready, 2'b00);
    chk("rst_to_wnn_tvalid", to_WNN_tvalid, 0);
    chk("rst_rsp_tvalid", rsp_tvalid, 2'b00);
    chk("rst_from_wnn_tready", from_WNN_tready, 1);
    chk("rst_pulses", {o_lock_timeout, o_stray_rsp}, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk);
    #1;

    // single CHECK
    exp_wnn.push_back({1'b0, 8'd1, 8'h05});
    exp_rsp.push_back({1'b0, 32'h10});
    send(0, 8'd1, 8'h05, 0);
    drain();
    chk("single_idle", o_grant, 2'b00);

    // atomic RMW under contention
    exp_wnn.push_back({1'b0, 8'd1, 8'h11});
    exp_wnn.push_back({1'b0, 8'd2, 8'h11});
    exp_wnn.push_back({1'b1, 8'd1, 8'h22});
    exp_rsp.push_back({1'b0, 32'h11});
    exp_rsp.push_back({1'b1, 32'h12});
    fork
      begin
        send(0, 8'd1, 8'h11, 1);
        send(0, 8'd2, 8'h11, 0);
      end
      begin
        @(posedge clk);
        #1;
        send(1, 8'd1, 8'h22, 0);
      end
      begin
        int early = 0;
        while (exp_wnn.size() > 1) begin
          @(negedge clk);
          if (o_grant[1] && exp_wnn.size() > 1) early++;
        end
        chk("rmw_no_early_grant1", early, 0);
      end
    join
    drain();

    // round robin
    for (int i = 0; i < 4; i++) begin
      exp_wnn.push_back({1'b0, 8'd1, 8'(8'h30 + i)});
      exp_rsp.push_back({1'b0, 32'(32'h13 + 2 * i)});
      exp_wnn.push_back({1'b1, 8'd1, 8'(8'h40 + i)});
      exp_rsp.push_back({1'b1, 32'(32'h14 + 2 * i)});
    end
    fork
      for (int i = 0; i < 4; i++) send(0, 8'd1, 8'(8'h30 + i), 0);
      for (int j = 0; j < 4; j++) send(1, 8'd1, 8'(8'h40 + j), 0);
    join
    drain();

    // NOP release
    exp_wnn.push_back({1'b0, 8'd1, 8'h50});
    exp_wnn.push_back({1'b1, 8'd1, 8'h60});
    exp_rsp.push_back({1'b0, 32'h1B});
    exp_rsp.push_back({1'b1, 32'h1C});
    fork
      begin
        send(0, 8'd1, 8'h50, 1);
        send(0, 8'd0, 8'h50, 0);
        chk("nop_idle", o_grant, 2'b00);
        @(posedge clk);
        #1;
        chk("nop_next_port1", o_grant, 2'b10);
      end
      begin
        @(posedge clk);
        #1;
        send(1, 8'd1, 8'h60, 0);
      end
    join
    drain();

    // abandoned lock
    exp_wnn.push_back({1'b0, 8'd1, 8'h70});
    exp_rsp.push_back({1'b0, 32'h1D});
`ifdef WNN_ARB_LOCK_TIMEOUT_EN
    exp_wnn.push_back({1'b1, 8'd1, 8'h71});
    exp_rsp.push_back({1'b1, 32'h1E});
    fork
      send(0, 8'd1, 8'h70, 1);
      begin
        @(posedge clk);
        #1;
        send(1, 8'd1, 8'h71, 0);
      end
    join
    drain();
    chk("timeout_pulses", to_cnt, 1);
    chk("timeout_delay", to_cyc - rsp0_cyc, 8);
`else
    send(0, 8'd1, 8'h70, 1);
    begin
      int bad = 0;
      drive(1, 1, 8'd1, 8'h71, 0);
      repeat (40) begin
        @(negedge clk);
        if (req_tready[1] || o_grant[1]) bad++;
      end
      @(posedge clk);
      #1;
      drive(1, 0, 8'd1, 8'h71, 0);
      chk("locked_port1_starved", bad, 0);
    end
    drain();
    chk("timeout_pulses", to_cnt, 0);
    chk("hold_grant", o_grant, 2'b01);
`endif

    // reset in WAIT_RSP, then a late response is stray
    rsp_en = 0;
    rsp_tready = 2'b10;
    exp_wnn.push_back({1'b0, 8'd1, 8'h80});
    send(0, 8'd1, 8'h80, 0);
    chk("wait_grant", o_grant, 2'b01);
    chk("wait_from_tready", from_WNN_tready, 0);
    #2;
    rst_n = 0;
    #1;
    chk("arst_grant", o_grant, 2'b00);
    chk("arst_from_tready", from_WNN_tready, 1);
    chk("arst_valids", {to_WNN_tvalid, rsp_tvalid, req_tready}, 0);
    @(negedge clk);
    rst_n = 1;
    rsp_tready = 2'b11;
    pend_q.delete();
    @(posedge clk);
    #1;
    from_WNN_tvalid = 1;
    from_WNN_tdata  = 32'hAB;
    @(negedge clk);
    chk("stray_pulse", o_stray_rsp, 1);
    chk("stray_no_rsp", rsp_tvalid, 2'b00);
    @(posedge clk);
    #1;
    from_WNN_tvalid = 0;
    @(negedge clk);
    chk("stray_clear", o_stray_rsp, 0);
    chk("stray_count", stray_cnt, 1);
    chk("final_queues", exp_wnn.size() + exp_rsp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wnn_seq_arbiter.md
# wnn_seq_arbiter

Two-requester arbiter that shares the single WAN Number Node (WNN) sequence-number repository between the KIP receive path (port 0) and the KIP transmit path (port 1). It serializes CHECK/WRITE request beats onto the one WNN request channel and routes each CHECK response back to the requester that issued it. A lock lets one requester hold the WNN across a CHECK -> WRITE read-modify-write so the two paths never interleave on a cluster's sequence number. Optionally, a timeout breaks an abandoned lock.

## Interface
- RPN_MSG_TYPE_WIDTH, 8: request message type width.
- AXIS_WAN_TDEST_WIDTH, 8: CTDEST (peer cluster ID) width.
- WAN_SEQUENCE_NUMBER_WIDTH, 32: response sequence number width.
- MSG_CHECK, 1: type that expects exactly one WNN response.
- MSG_NOP, 0: lock-release-only type; consumed locally and never forwarded.
- LOCK_TIMEOUT_CYCLES, 256: idle cycles in HOLD before forced release (>=2).

Ports:
- i_clk  in  1  clock.
- i_ap_rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- req_tvalid / req_tready  in / out  2  per-port request handshake.
- req_tdata  in  2*RPN_MSG_TYPE_WIDTH  per-port message type.
- req_tdest  in  2*AXIS_WAN_TDEST_WIDTH  per-port CTDEST.
- req_tuser  in  2  per-port lock; 1 = keep grant after this beat.
- rsp_tvalid / rsp_tready  out / in  2  per-port response handshake.
- rsp_tdata  out  WAN_SEQUENCE_NUMBER_WIDTH  response sequence number, shared by both ports.
- rsp_tdest  out  AXIS_WAN_TDEST_WIDTH  response CTDEST, shared by both ports.
- rsp_tuser  out  1  response lock bit, shared by both ports.
- to_WNN_tvalid / to_WNN_tready  out / in  1  request to WNN.
- to_WNN_tdata  out  RPN_MSG_TYPE_WIDTH  message type to WNN.
- to_WNN_tdest  out  AXIS_WAN_TDEST_WIDTH  CTDEST to WNN.
- from_WNN_tvalid / from_WNN_tready  in / out  1  WNN response handshake.
- from_WNN_tdata  in  WAN_SEQUENCE_NUMBER_WIDTH  response sequence number.
- from_WNN_tdest  in  AXIS_WAN_TDEST_WIDTH  response CTDEST.
- from_WNN_tuser  in  1  response lock bit.
- o_grant  out  2  one-hot current owner; 0 when no owner.
- o_lock_timeout  out  1  one-cycle pulse on forced release.
- o_stray_rsp  out  1  one-cycle pulse when an unexpected WNN response is dropped.

## Operation

**States.** IDLE, FWD, WAIT_RSP, HOLD. g is the registered grant index; r_lock and r_tdest are latched from the accepted beat.

**IDLE**
- No grant; all req_tready, to_WNN_tvalid and rsp_tvalid are 0.
- If any req_tvalid is set, pick g and go to FWD.
- Round-robin: if both ports are valid, grant the port not granted last. The last-grant pointer resets to 1, so port 0 wins the first tie.

**FWD**
- Combinational pass-through of port g only: to_WNN_tvalid = req_tvalid[g], req_tready[g] = to_WNN_tready. tdata and tdest are muxed from port g.
- If req_tdata[g] == MSG_NOP: to_WNN_tvalid = 0 and req_tready[g] = 1; the beat is consumed locally.
- On an accepted beat:
  - CHECK -> WAIT_RSP.
  - Any other type with tuser = 1 -> HOLD.
  - Otherwise -> IDLE.
- A CHECK beat latches its tuser into r_lock and its tdest into r_tdest.

**WAIT_RSP**
- rsp_tvalid[g] = from_WNN_tvalid and from_WNN_tready = rsp_tready[g]; rsp data passes through combinationally.
- On handshake: r_lock = 1 -> HOLD, else -> IDLE.
- A response whose tdest differs from r_tdest is still delivered.

**HOLD**
- Grant retained; the other port is never granted; to_WNN_tvalid = 0.
- req_tvalid[g] -> FWD next cycle and the timeout counter clears.

**Stray responses.** In any state other than WAIT_RSP, from_WNN_tready = 1; any arriving beat is dropped and pulses o_stray_rsp.

**Counter width.** The timeout counter is $clog2(LOCK_TIMEOUT_CYCLES) bits and saturates; it never wraps.

## Timing
- Reset values:
  - State IDLE, g = 0, last-grant pointer = 1, r_lock = 0, counter = 0.
  - Outputs: o_grant = 0, pulses = 0, all tvalid = 0, all tready = 0 except from_WNN_tready = 1.
- Grant latency: 1 cycle from req_tvalid in IDLE to the FWD pass-through. Inside FWD and WAIT_RSP the path is zero-latency combinational.
- Lock release: a WRITE or NOP with tuser = 0 returns to IDLE the next cycle. A back-to-back request from the other port is granted 1 cycle after that.
- Simultaneous events:
  - Both ports valid in IDLE: round-robin decides.
  - Release and a new request from the same port in the same cycle: that port re-arbitrates normally in IDLE.
- tvalid, once asserted, is held until its handshake completes; the arbiter never withdraws a forwarded to_WNN_tvalid mid-beat.
- Reset mid-transaction: asynchronous return to reset values. An in-flight WNN response that arrives after reset is treated as stray.

## Configuration
- WNN_ARB_LOCK_TIMEOUT_EN defined:
  - HOLD counts cycles with req_tvalid[g] = 0.
  - At LOCK_TIMEOUT_CYCLES-1 the block goes to IDLE, pulses o_lock_timeout and clears r_lock.
- Undefined:
  - The counter logic is absent and o_lock_timeout is tied to 0.
  - HOLD persists until the owner sends an unlocked beat.

## Test plan
- Single CHECK, lock = 0:
  - Port 0 sends type 1, tdest 0x05; WNN replies tdata 0x10.
  - Required: one to_WNN beat; rsp_tvalid[0] with 0x10; rsp_tvalid[1] stays 0; back in IDLE.
- Atomic RMW under contention:
  - Port 0 sends CHECK with lock = 1 then WRITE with lock = 0, while port 1 holds CHECK valid throughout.
  - Required: to_WNN order is 0:CHECK, 0:WRITE, 1:CHECK; o_grant[1] is never set before the WRITE is accepted.
- Round-robin: both ports assert CHECK lock = 0 together, repeated 4 times -> grant order 0, 1, 0, 1.
- NOP release:
  - Port 0 sends CHECK lock = 1, the response completes, then port 0 sends NOP lock = 0.
  - Required: no NOP on to_WNN; IDLE within 1 cycle; port 1 granted next.
- Timeout (macro on, LOCK_TIMEOUT_CYCLES = 8):
  - Port 0 sends CHECK lock = 1, then goes silent.
  - Required: o_lock_timeout pulses exactly once, 8 cycles into HOLD; port 1 is then served.
  - Macro off: port 1 is never served.
- Stray response and reset:
  - A WNN beat in IDLE -> dropped, o_stray_rsp = 1 for 1 cycle.
  - i_ap_rst_n low in WAIT_RSP -> all outputs at reset values immediately.
